fir_tap_sequencer: RTL
======================

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 Parameter NTAPS, 16, number of filter taps; must be a power of two.
REQ-002 Parameter ALU_LAT, 1, cycles from operands presented to the alu to alu_result valid.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 coef_we  in  1  coefficient write strobe.
REQ-006 coef_addr  in  log2(NTAPS)  coefficient index k.
REQ-007 coef_wdata  in  16  signed coefficient h[k].
REQ-008 in_valid  in  1  input sample offered.
REQ-009 in_ready  out  1  block can accept a sample.
REQ-010 in_data  in  16  signed sample x[n].
REQ-011 alu_op_sel  out  2  operation select to the alu: 2'b01 is multiply, 2'b00 is add.
REQ-012 alu_a  out  16  signed operand a to the alu (sample).
REQ-013 alu_b  out  16  signed operand b to the alu (coefficient).
REQ-014 alu_result  in  32  signed alu result.
REQ-015 out_valid  out  1  filtered output available.
REQ-016 out_ready  in  1  downstream accepts the output.
REQ-017 out_data  out  32  signed y[n].
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have four states:
- IDLE -> ISSUE on in_valid && in_ready.
- ISSUE -> DRAIN after tap NTAPS-1 is issued.
- DRAIN -> OUT once the last product is accumulated.
- OUT -> IDLE on out_valid && out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 On accept:
- in_data is written to the circular delay line at wr_ptr.
- wr_ptr advances mod NTAPS.
- the accumulator clears to 0.
- tap counter k is set to 0.
REQ-022 In ISSUE, one tap per cycle, k = 0..NTAPS-1:
- alu_a = x[n-k], newest sample first, with the index wrapping mod NTAPS.
- alu_b = h[k].
- alu_op_sel = 2'b01.
REQ-023 Outside ISSUE, alu_a and alu_b SHALL be 0 and alu_op_sel SHALL be 2'b00.
REQ-024 A valid shift pipe of depth ALU_LAT SHALL track issued taps; alu_result is added to the accumulator only on cycles when the pipe output is set.
REQ-025 The accumulator SHALL be 32-bit two's complement and wrap on overflow with no saturation.
REQ-026 out_valid SHALL rise exactly NTAPS+ALU_LAT+1 rising edges after the accepting edge (18 for defaults).
REQ-027 While out_valid && !out_ready:
- out_data is held stable.
- no new sample is accepted.
REQ-028 out_data SHALL equal the accumulator in OUT and 0 otherwise.
REQ-029 Coefficient writes are taken only in IDLE; coef_we in any other state is ignored and has no effect.
REQ-030 If coef_we and an accepted in_valid occur in the same IDLE cycle, both SHALL take effect, and the new coefficient SHALL apply to this sample.
REQ-031 Initial state: delay line and coefficients are zero until loaded, giving zero-padded start-up.

Reset
REQ-032 While rst = 1, the block SHALL asynchronously force:
- state to IDLE.
- in_ready = 1.
- out_valid = 0, out_data = 0, busy = 0.
- alu_a = alu_b = 0, alu_op_sel = 2'b00.
- wr_ptr, k, accumulator and valid pipe to 0.
- all delay-line entries and coefficients to 0.
REQ-033 rst asserted in any state, including mid-ISSUE or OUT, SHALL abort the operation with no partial output produced.

Verification
REQ-034 Impulse: load h[k] = k+1, feed 1 then 15 zeros -> out_data sequence 1, 2, ..., 16.
REQ-035 Latency: one accepted sample with defaults -> out_valid rises on the 18th edge after acceptance; alu_op_sel = 01 for exactly 16 consecutive cycles.
REQ-036 Overflow wrap: all h = 32767, feed sixteen samples of 32767 -> 16th out_data = -1048560 (0xFFF00010).
REQ-037 Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_data stable, in_ready = 0, no sample accepted until the output handshake completes.
REQ-038 Coefficient write while busy: write h[0] = 100 during ISSUE -> write ignored; a later impulse shows the old h[0].
REQ-039 Reset mid-ISSUE: assert rst at k = 5 -> no out_valid; after release in_ready = 1, and the next sample yields out_data = 0 because coefficients are cleared.

Source files
------------

// File: rtl/fir_tap_sequencer_if.sv
// Sample/coefficient/output handshakes plus the external alu operand bus.
// The master side is the environment, which also owns the alu.
interface fir_tap_sequencer_if #(
  parameter int unsigned NTAPS = 16
) ();
  localparam int unsigned AW = $clog2(NTAPS);

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [1:0]    alu_op_sel;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [31:0]   alu_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;

  modport master (
    output coef_we, coef_addr, coef_wdata, in_valid, in_data, alu_result, out_ready,
    input  in_ready, alu_op_sel, alu_a, alu_b, out_valid, out_data, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_wdata, in_valid, in_data, alu_result, out_ready,
    output in_ready, alu_op_sel, alu_a, alu_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: issues one tap per cycle to an external alu and
// accumulates the returned products into a wrapping 32-bit sum.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS   = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_tap_sequencer_if.slave   bus
);
  localparam int unsigned AW = $clog2(NTAPS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t               state_q;
  logic [15:0]          dline_q [NTAPS];
  logic [15:0]          coef_q  [NTAPS];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        k_q;
  logic [31:0]          acc_q;
  logic [ALU_LAT-1:0]   vpipe_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic [31:0]          out_data_q;
  logic [1:0]           alu_op_q;
  logic [15:0]          alu_a_q;
  logic [15:0]          alu_b_q;

  logic [AW-1:0]        k_d;
  logic [AW-1:0]        rd_ptr_d;
  logic [31:0]          acc_d;
  logic                 issue_d;
  logic                 accept_d;

  // wr_ptr_q already points past x[n], so x[n-k] sits at wr_ptr_q-1-k.
  always_comb begin
    k_d      = k_q + 1'b1;
    rd_ptr_d = wr_ptr_q - AW'(1) - k_d;
    issue_d  = (state_q == ISSUE);
    accept_d = in_ready_q && bus.in_valid;
    acc_d    = vpipe_q[ALU_LAT-1] ? acc_q + bus.alu_result : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      vpipe_q     <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      alu_op_q    <= 2'b00;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      vpipe_q <= (vpipe_q << 1) | ALU_LAT'(issue_d);
      acc_q   <= acc_d;
      case (state_q)
        IDLE: begin
          if (bus.coef_we) coef_q[bus.coef_addr] <= bus.coef_wdata;
          if (accept_d) begin
            dline_q[wr_ptr_q] <= bus.in_data;
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            acc_q      <= '0;
            k_q        <= '0;
            // Tap 0 is presented straight from the ports so a same-cycle h[0] write applies.
            alu_a_q    <= bus.in_data;
            alu_b_q    <= (bus.coef_we && bus.coef_addr == '0) ? bus.coef_wdata : coef_q[0];
            alu_op_q   <= 2'b01;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (k_q == AW'(NTAPS - 1)) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 2'b00;
            state_q  <= DRAIN;
          end else begin
            k_q     <= k_d;
            alu_a_q <= dline_q[rd_ptr_d];
            alu_b_q <= coef_q[k_d];
          end
        end
        DRAIN: begin
          if (vpipe_q == '0) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.alu_op_sel = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
endmodule
